// File: rtl/ccip_wr_engine.sv
// CCI-P c1 host-write issue stage: streams num_lines upstream lines as single-line WrLine requests.
// Optional job cycle counter on perf_cycles when CCIP_WR_ENGINE_PERF_EN is defined.
module ccip_wr_engine #(
  parameter int unsigned MAX_OUTSTANDING = 32,
  parameter int unsigned LINES_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [41:0]        base_cl_addr,
  input  logic [LINES_W-1:0] num_lines,
  input  logic               wr_data_valid,
  input  logic [511:0]       wr_data,
  output logic               wr_data_ready,
  input  logic               c1_tx_alm_full,
  output logic               c1_tx_valid,
  output logic [41:0]        c1_tx_addr,
  output logic [15:0]        c1_tx_mdata,
  output logic [511:0]       c1_tx_data,
  input  logic               c1_rx_rsp_valid,
  output logic               busy,
  output logic               done,
  output logic [LINES_W-1:0] lines_acked,
  output logic [31:0]        perf_cycles
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OutW-1:0] OutMax = OutW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e             state_q;
  logic [41:0]        base_q;
  logic [LINES_W-1:0] total_q;
  logic [LINES_W-1:0] issued_q;
  logic [LINES_W-1:0] acked_q;
  logic [OutW-1:0]    outstanding_q;

  logic accept;
  logic rsp_hit;
  logic last_line;

  assign busy        = (state_q == StIssue) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign lines_acked = acked_q;

  // Ready depends only on registered state and alm_full, never on wr_data_valid.
  assign wr_data_ready = (state_q == StIssue) && (issued_q < total_q) && !c1_tx_alm_full &&
                         (outstanding_q < OutMax);
  assign accept        = wr_data_ready && wr_data_valid;
  // Responses outside an active job, or beyond the line count, are dropped.
  assign rsp_hit       = c1_rx_rsp_valid && busy && (acked_q < total_q);
  assign last_line     = (issued_q + LINES_W'(1)) == total_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      base_q        <= '0;
      total_q       <= '0;
      issued_q      <= '0;
      acked_q       <= '0;
      outstanding_q <= '0;
      c1_tx_valid   <= 1'b0;
      c1_tx_addr    <= '0;
      c1_tx_mdata   <= '0;
      c1_tx_data    <= '0;
    end else begin
      c1_tx_valid <= accept;
      if (accept) begin
        c1_tx_addr  <= base_q + 42'(issued_q);
        c1_tx_mdata <= 16'(issued_q);
        c1_tx_data  <= wr_data;
        issued_q    <= issued_q + LINES_W'(1);
      end

      if (rsp_hit) begin
        acked_q <= acked_q + LINES_W'(1);
      end

      if (accept && !rsp_hit) begin
        outstanding_q <= outstanding_q + OutW'(1);
      end else if (!accept && rsp_hit && (outstanding_q != '0)) begin
        outstanding_q <= outstanding_q - OutW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_q        <= base_cl_addr;
            total_q       <= num_lines;
            issued_q      <= '0;
            acked_q       <= '0;
            outstanding_q <= '0;
            state_q       <= (num_lines == '0) ? StDone : StIssue;
          end
        end
        StIssue: begin
          if (accept && last_line) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (acked_q == total_q) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef CCIP_WR_ENGINE_PERF_EN
  logic [31:0] perf_q;

  // Stops counting in DONE, so the final job length holds until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      perf_q <= '0;
    end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ccip_wr_engine.sv
// Randomized self-checking bench for ccip_wr_engine; reference model tracks lines, acks and timing.
module tb_ccip_wr_engine;

  localparam int MAX_OUT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [41:0]  base_cl_addr = '0;
  logic [15:0]  num_lines = '0;
  logic         wr_data_valid = 1'b0;
  logic [511:0] wr_data = '0;
  logic         wr_data_ready;
  logic         c1_tx_alm_full = 1'b0;
  logic         c1_tx_valid;
  logic [41:0]  c1_tx_addr;
  logic [15:0]  c1_tx_mdata;
  logic [511:0] c1_tx_data;
  logic         c1_rx_rsp_valid = 1'b0;
  logic         busy;
  logic         done;
  logic [15:0]  lines_acked;
  logic [31:0]  perf_cycles;

  ccip_wr_engine #(
    .MAX_OUTSTANDING(MAX_OUT),
    .LINES_W        (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_cl_addr   (base_cl_addr),
    .num_lines      (num_lines),
    .wr_data_valid  (wr_data_valid),
    .wr_data        (wr_data),
    .wr_data_ready  (wr_data_ready),
    .c1_tx_alm_full (c1_tx_alm_full),
    .c1_tx_valid    (c1_tx_valid),
    .c1_tx_addr     (c1_tx_addr),
    .c1_tx_mdata    (c1_tx_mdata),
    .c1_tx_data     (c1_tx_data),
    .c1_rx_rsp_valid(c1_rx_rsp_valid),
    .busy           (busy),
    .done           (done),
    .lines_acked    (lines_acked),
    .perf_cycles    (perf_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [41:0]  addr;
    logic [15:0]  mdata;
    logic [511:0] data;
  } req_t;

  req_t exp_q[$];
  int   due_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state
  logic [41:0] base_m = '0;
  int  n_m = 0;
  int  issued_m = 0;
  int  acked_m = 0;
  bit  job_m = 1'b0;
  bit  acc_prev = 1'b0;
  bit  done_sched = 1'b1;
  int  last_acc = 0;
  int  last_rsp = 0;
  int  exp_done_cyc = -1;
  int  start_cyc = 0;
  int  req_cnt = 0;

  // Stimulus knobs
  int unsigned valid_pct = 100;
  int unsigned alm_pct = 0;
  bit          alm_force = 1'b0;
  bit          withhold = 1'b0;
  int          rel_budget = 0;
  int unsigned dly_lo = 3;
  int unsigned dly_hi = 3;
  int          last_due = 0;
  bit          start_req = 1'b0;
  logic [41:0] base_req = '0;
  logic [15:0] n_req = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    req_t r;
    bit   exp_ready;
    int   due;
    @(posedge clk);
    #1;
    cyc++;
    // Registered outputs produced by the previous edge
    chk("tx_valid", 64'(c1_tx_valid), 64'(acc_prev));
    if (c1_tx_valid) begin
      req_cnt++;
      chk("tx_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("tx_addr", 64'(c1_tx_addr), 64'(r.addr));
        chk("tx_mdata", 64'(c1_tx_mdata), 64'(r.mdata));
        chk_data("tx_data", c1_tx_data, r.data);
      end
      due = cyc + int'($urandom_range(dly_hi, dly_lo));
      last_due = (due > last_due) ? due : last_due;
      due_q.push_back(last_due);
    end
    chk("done", 64'(done), 64'(cyc == exp_done_cyc));
    chk("busy", 64'(busy), 64'(job_m && (cyc != exp_done_cyc)));
    if (cyc == exp_done_cyc) begin
      chk("lines_acked", 64'(lines_acked), 64'(n_m[15:0]));
`ifdef CCIP_WR_ENGINE_PERF_EN
      chk("perf_cycles", 64'(perf_cycles), 64'(cyc - start_cyc - 1));
`else
      chk("perf_off", 64'(perf_cycles), 64'(0));
`endif
      job_m = 1'b0;
    end

    // Drive this cycle's inputs
    c1_rx_rsp_valid = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= cyc && (!withhold || rel_budget > 0)) begin
      void'(due_q.pop_front());
      c1_rx_rsp_valid = 1'b1;
      if (withhold) rel_budget--;
    end
    c1_tx_alm_full = alm_force || ($urandom_range(99) < alm_pct);
    wr_data_valid  = $urandom_range(99) < valid_pct;
    for (int i = 0; i < 16; i++) wr_data[i*32 +: 32] = $urandom;
    start        = start_req;
    base_cl_addr = base_req;
    num_lines    = n_req;
    start_req    = 1'b0;
    #1;

    exp_ready = job_m && (issued_m < n_m) && !c1_tx_alm_full && ((issued_m - acked_m) < MAX_OUT);
    chk("ready", 64'(wr_data_ready), 64'(exp_ready));
    acc_prev = exp_ready && wr_data_valid;
    if (acc_prev) begin
      exp_q.push_back('{addr: base_m + 42'(issued_m), mdata: 16'(issued_m), data: wr_data});
      issued_m++;
      last_acc = cyc;
    end
    if (c1_rx_rsp_valid && job_m && (acked_m < n_m) && !rst) begin
      acked_m++;
      last_rsp = cyc;
    end
    if (start && !job_m && (cyc != exp_done_cyc) && !rst) begin
      base_m     = base_cl_addr;
      n_m        = int'(num_lines);
      issued_m   = 0;
      acked_m    = 0;
      job_m      = 1'b1;
      done_sched = 1'b0;
      start_cyc  = cyc;
      last_acc   = cyc - 1;
      last_rsp   = cyc - 1;
    end
    // DONE follows one DRAIN cycle after both the last issue and the last ack have registered
    if (job_m && !done_sched && issued_m == n_m && acked_m == n_m) begin
      exp_done_cyc = ((last_acc > last_rsp) ? last_acc : last_rsp) + 2;
      done_sched   = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    job_m        = 1'b0;
    acc_prev     = 1'b0;
    done_sched   = 1'b1;
    exp_done_cyc = -1;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_job(input logic [41:0] b, input logic [15:0] n);
    start_req = 1'b1;
    base_req  = b;
    n_req     = n;
    tick();
  endtask

  task automatic run_to_done(input int bound);
    int k = 0;
    while (job_m && k < bound) begin
      tick();
      k++;
    end
    chk("job_completes", 64'(job_m), 64'(0));
    chk("no_pending_req", 64'(exp_q.size()), 64'(0));
    tick();
  endtask

  initial begin
    int r0;
    int k;
    do_reset();
    chk("rst_tx_addr", 64'(c1_tx_addr), 64'(0));
    chk("rst_tx_mdata", 64'(c1_tx_mdata), 64'(0));
    chk_data("rst_tx_data", c1_tx_data, 512'(0));
    chk("rst_lines_acked", 64'(lines_acked), 64'(0));
    chk("rst_perf", 64'(perf_cycles), 64'(0));

    // Basic 4-line job, fixed 3-cycle response latency
    start_job(42'h100, 16'd4);
    run_to_done(200);
    chk("basic_lines_acked", 64'(lines_acked), 64'(4));

    // Zero-length job
    start_job(42'h200, 16'd0);
    run_to_done(10);

    // Outstanding limit with responses withheld
    withhold = 1'b1;
    r0 = req_cnt;
    start_job(42'h1000, 16'd5);
    for (int i = 0; i < 10; i++) tick();
    chk("limit_reqs", 64'(req_cnt - r0), 64'(MAX_OUT));
    rel_budget = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("limit_release_one", 64'(req_cnt - r0), 64'(MAX_OUT + 1));
    withhold = 1'b0;
    run_to_done(200);

    // Almost-full held for 10 cycles mid-job
    start_job(42'h2000, 16'd8);
    for (int i = 0; i < 3; i++) tick();
    alm_force = 1'b1;
    r0 = req_cnt;
    for (int i = 0; i < 10; i++) tick();
    chk("alm_hold_reqs", 64'(req_cnt - r0 <= 1), 64'(1));
    alm_force = 1'b0;
    run_to_done(200);
    chk("alm_lines_acked", 64'(lines_acked), 64'(8));

    // Address wrap at 2^42
    start_job(42'h3FF_FFFF_FFFF, 16'd2);
    run_to_done(100);

    // Start while busy is ignored
    start_job(42'h3000, 16'd6);
    tick();
    tick();
    start_req = 1'b1;
    base_req  = 42'h5555;
    n_req     = 16'd1;
    tick();
    run_to_done(200);
    chk("busy_start_ignored", 64'(lines_acked), 64'(6));

    // Randomized jobs
    for (int j = 0; j < 5; j++) begin
      valid_pct = $urandom_range(100, 40);
      alm_pct   = $urandom_range(30, 0);
      dly_lo    = 1;
      dly_hi    = $urandom_range(10, 1);
      start_job(42'({$urandom, $urandom}), 16'($urandom_range(20, 1)));
      run_to_done(3000);
    end

    // Reset with 3 writes outstanding; stale responses land in IDLE
    valid_pct = 100;
    alm_pct   = 0;
    dly_lo    = 3;
    dly_hi    = 3;
    withhold  = 1'b1;
    r0 = req_cnt;
    start_job(42'h4000, 16'd5);
    k = 0;
    while ((req_cnt - r0) < 3 && k < 20) begin
      tick();
      k++;
    end
    chk("pre_reset_reqs", 64'(req_cnt - r0), 64'(3));
    do_reset();
    withhold = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("stale_pending", 64'(due_q.size()), 64'(0));
    chk("stale_ignored", 64'(lines_acked), 64'(0));
    start_job(42'h5000, 16'd1);
    run_to_done(100);
    chk("post_reset_lines_acked", 64'(lines_acked), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
